// File: rtl/lock_sequencer.sv
// Combination lock sequencer: digit entry, reprogramming and optional lockout.
// Define LOCKOUT_EN to add the LOCKOUT state entered on the third consecutive failure.
module lock_sequencer #(
  parameter int unsigned         DIGITS       = 6,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 24'h285591,
  parameter int unsigned         LOCK_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enter,
  input  logic [3:0] digit,
  input  logic       prog,
  output logic [2:0] status,
  output logic [2:0] digit_idx,
  output logic [1:0] fail_cnt,
  output logic       locked
);

  localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {
    S_ENTRY   = 3'd0,
    S_OPEN    = 3'd1,
    S_CLOSED  = 3'd2,
    S_ERROR   = 3'd3,
`ifdef LOCKOUT_EN
    S_PROG    = 3'd4,
    S_LOCKOUT = 3'd5
`else
    S_PROG    = 3'd4
`endif
  } state_t;

  state_t                 state_q;
  logic [DIGITS-1:0][3:0] code_q;
  logic [DIGITS-1:0][3:0] shadow_q;
  logic [DIGITS-1:0][3:0] shadow_c;
  logic                   miss_q;
  logic [IDXW-1:0]        pos_c;
  logic                   valid_c;
  logic                   last_c;
  logic                   mismatch_c;
  logic [1:0]             fail_inc_c;

`ifdef LOCKOUT_EN
  localparam int unsigned TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  logic [TW-1:0] timer_q;
`else
  assign locked = 1'b0;
`endif

  // Digit 0 lives in the most-significant nibble, so index from the top.
  assign pos_c      = IDXW'(3'(DIGITS - 1) - digit_idx);
  assign valid_c    = (digit <= 4'd9);
  assign last_c     = (digit_idx == 3'(DIGITS - 1));
  assign mismatch_c = (digit != code_q[pos_c]);
  assign fail_inc_c = (fail_cnt == 2'd3) ? 2'd3 : fail_cnt + 2'd1;
  assign status     = 3'(state_q);

  // Shadow code with the current digit merged in, used for both store and commit.
  always_comb begin
    shadow_c        = shadow_q;
    shadow_c[pos_c] = digit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_ENTRY;
      digit_idx <= 3'd0;
      miss_q    <= 1'b0;
      fail_cnt  <= 2'd0;
      code_q    <= DEFAULT_CODE;
      shadow_q  <= DEFAULT_CODE;
`ifdef LOCKOUT_EN
      locked    <= 1'b0;
      timer_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_ENTRY: begin
          if (enter) begin
            if (!valid_c) begin
              state_q   <= S_ERROR;
              digit_idx <= 3'd0;
              miss_q    <= 1'b0;
            end else if (last_c) begin
              digit_idx <= 3'd0;
              miss_q    <= 1'b0;
              if (miss_q || mismatch_c) begin
                fail_cnt <= fail_inc_c;
`ifdef LOCKOUT_EN
                if (fail_inc_c == 2'd3) begin
                  state_q <= S_LOCKOUT;
                  locked  <= 1'b1;
                  timer_q <= TW'(LOCK_CYCLES - 1);
                end else begin
                  state_q <= S_CLOSED;
                end
`else
                state_q <= S_CLOSED;
`endif
              end else begin
                state_q  <= S_OPEN;
                fail_cnt <= 2'd0;
              end
            end else begin
              digit_idx <= digit_idx + 3'd1;
              miss_q    <= miss_q | mismatch_c;
            end
          end
        end
        S_OPEN: begin
          if (enter) begin
            state_q   <= prog ? S_PROG : S_ENTRY;
            digit_idx <= 3'd0;
            shadow_q  <= code_q;
          end
        end
        S_PROG: begin
          if (enter) begin
            if (!valid_c) begin
              state_q   <= S_ERROR;
              digit_idx <= 3'd0;
              shadow_q  <= code_q;
            end else if (last_c) begin
              state_q   <= S_ENTRY;
              digit_idx <= 3'd0;
              shadow_q  <= shadow_c;
              code_q    <= shadow_c;
            end else begin
              digit_idx <= digit_idx + 3'd1;
              shadow_q  <= shadow_c;
            end
          end
        end
        S_CLOSED, S_ERROR: begin
          if (enter) begin
            state_q   <= S_ENTRY;
            digit_idx <= 3'd0;
            miss_q    <= 1'b0;
          end
        end
`ifdef LOCKOUT_EN
        // Enter is ignored while the timer runs down.
        S_LOCKOUT: begin
          if (timer_q == '0) begin
            state_q  <= S_ENTRY;
            fail_cnt <= 2'd0;
            locked   <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
`endif
        default: begin
          state_q   <= S_ENTRY;
          digit_idx <= 3'd0;
          miss_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: scoreboarded enter sequences per scenario.
// Builds with or without LOCKOUT_EN; the failure-limit scenario adapts to the build.
module tb_lock_sequencer;

  localparam int LOCK = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enter;
  logic [3:0] digit;
  logic       prog;
  logic [2:0] status;
  logic [2:0] digit_idx;
  logic [1:0] fail_cnt;
  logic       locked;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] idx;
    logic [1:0] fc;
    logic       lk;
  } exp_t;

  typedef struct packed {
    logic [3:0] d;
    logic       p;
    exp_t       e;
  } step_t;

  step_t plan[$];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;

  lock_sequencer #(
    .DIGITS      (6),
    .DEFAULT_CODE(24'h285591),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enter    (enter),
    .digit    (digit),
    .prog     (prog),
    .status   (status),
    .digit_idx(digit_idx),
    .fail_cnt (fail_cnt),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  function automatic void add(int d, int p, int st, int idx, int fc, int lk);
    step_t s;
    s.d    = 4'(d);
    s.p    = 1'(p);
    s.e.st = 3'(st);
    s.e.idx = 3'(idx);
    s.e.fc = 2'(fc);
    s.e.lk = 1'(lk);
    plan.push_back(s);
  endfunction

  // One six-digit attempt: intermediate expectations then the final outcome.
  function automatic void add_seq(logic [23:0] code, int mid_st, int mid_fc,
                                  int fin_st, int fin_fc, int fin_lk);
    for (int i = 0; i < 6; i++) begin
      logic [3:0] d;
      d = code[23-4*i -: 4];
      if (i < 5) add(int'(d), 0, mid_st, i + 1, mid_fc, 0);
      else       add(int'(d), 0, fin_st, 0, fin_fc, fin_lk);
    end
  endfunction

  task automatic drive(input step_t s);
    @(negedge clk);
    enter = 1'b1;
    digit = s.d;
    prog  = s.p;
    sb.push_back(s.e);
    @(negedge clk);
    enter = 1'b0;
    prog  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({status, digit_idx, fail_cnt, locked} !== 9'b0) begin
      errors++;
      $display("FAIL reset: got st=%0d idx=%0d fc=%0d lk=%0d, want all 0",
               status, digit_idx, fail_cnt, locked);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({status, digit_idx, fail_cnt, locked} !== 9'b0) begin
      errors++;
      $display("FAIL reset_hold: got st=%0d idx=%0d fc=%0d lk=%0d, want all 0",
               status, digit_idx, fail_cnt, locked);
    end
  endtask

  task automatic test_open();
    exp_t e;
    int   n = 0;
    apply_reset();
    add_seq(24'h285591, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      e = sb.pop_front();
      checks++;
      if ({status, digit_idx, fail_cnt, locked} !== e) begin
        errors++;
        $display("FAIL open step %0d: got st=%0d idx=%0d fc=%0d lk=%0d, want st=%0d idx=%0d fc=%0d lk=%0d",
                 n, status, digit_idx, fail_cnt, locked, e.st, e.idx, e.fc, e.lk);
      end
      n++;
    end
  endtask

  task automatic test_error();
    exp_t e;
    int   n = 0;
    apply_reset();
    add(10, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(2, 0, 0, 1, 0, 0);
    add(8, 0, 0, 2, 0, 0);
    add(15, 0, 3, 0, 0, 0);
    add(3, 0, 0, 0, 0, 0);
    add(9, 0, 0, 1, 0, 0);
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      e = sb.pop_front();
      checks++;
      if ({status, digit_idx, fail_cnt, locked} !== e) begin
        errors++;
        $display("FAIL error step %0d: got st=%0d idx=%0d fc=%0d lk=%0d, want st=%0d idx=%0d fc=%0d lk=%0d",
                 n, status, digit_idx, fail_cnt, locked, e.st, e.idx, e.fc, e.lk);
      end
      n++;
    end
  endtask

  task automatic test_closed();
    exp_t e;
    int   n = 0;
    apply_reset();
    add_seq(24'h185591, 0, 0, 2, 1, 0);
    add(0, 0, 0, 0, 1, 0);
    add_seq(24'h285592, 0, 1, 2, 2, 0);
    add(0, 0, 0, 0, 2, 0);
    add(11, 0, 3, 0, 2, 0);
    add(0, 0, 0, 0, 2, 0);
    add_seq(24'h285591, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      e = sb.pop_front();
      checks++;
      if ({status, digit_idx, fail_cnt, locked} !== e) begin
        errors++;
        $display("FAIL closed step %0d: got st=%0d idx=%0d fc=%0d lk=%0d, want st=%0d idx=%0d fc=%0d lk=%0d",
                 n, status, digit_idx, fail_cnt, locked, e.st, e.idx, e.fc, e.lk);
      end
      n++;
    end
  endtask

  task automatic test_prog();
    exp_t e;
    int   n = 0;
    apply_reset();
    add_seq(24'h285591, 0, 0, 1, 0, 0);
    add(12, 1, 4, 0, 0, 0);
    add_seq(24'h123456, 4, 0, 0, 0, 0);
    add_seq(24'h285591, 0, 0, 2, 1, 0);
    add(0, 0, 0, 0, 1, 0);
    add_seq(24'h123456, 0, 1, 1, 0, 0);
    add(0, 1, 4, 0, 0, 0);
    add(7, 0, 4, 1, 0, 0);
    add(7, 0, 4, 2, 0, 0);
    add(10, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add_seq(24'h123456, 0, 0, 1, 0, 0);
    add(0, 1, 4, 0, 0, 0);
    add(9, 0, 4, 1, 0, 0);
    add(9, 0, 4, 2, 0, 0);
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      e = sb.pop_front();
      checks++;
      if ({status, digit_idx, fail_cnt, locked} !== e) begin
        errors++;
        $display("FAIL prog step %0d: got st=%0d idx=%0d fc=%0d lk=%0d, want st=%0d idx=%0d fc=%0d lk=%0d",
                 n, status, digit_idx, fail_cnt, locked, e.st, e.idx, e.fc, e.lk);
      end
      n++;
    end
    // Reset mid-programming restores the power-on code.
    apply_reset();
    add_seq(24'h123456, 0, 0, 2, 1, 0);
    add(0, 0, 0, 0, 1, 0);
    add_seq(24'h285591, 0, 1, 1, 0, 0);
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      e = sb.pop_front();
      checks++;
      if ({status, digit_idx, fail_cnt, locked} !== e) begin
        errors++;
        $display("FAIL prog_reset step %0d: got st=%0d idx=%0d fc=%0d lk=%0d, want st=%0d idx=%0d fc=%0d lk=%0d",
                 n, status, digit_idx, fail_cnt, locked, e.st, e.idx, e.fc, e.lk);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   n = 0;
    apply_reset();
    add(2, 0, 0, 1, 0, 0);
    add(8, 0, 0, 2, 0, 0);
    add(5, 0, 0, 3, 0, 0);
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      e = sb.pop_front();
      checks++;
      if ({status, digit_idx, fail_cnt, locked} !== e) begin
        errors++;
        $display("FAIL reset_mid step %0d: got st=%0d idx=%0d fc=%0d lk=%0d, want st=%0d idx=%0d fc=%0d lk=%0d",
                 n, status, digit_idx, fail_cnt, locked, e.st, e.idx, e.fc, e.lk);
      end
      n++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (status !== 3'd0 || digit_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_async: got st=%0d idx=%0d, want st=0 idx=0", status, digit_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    add_seq(24'h285591, 0, 0, 1, 0, 0);
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      e = sb.pop_front();
      checks++;
      if ({status, digit_idx, fail_cnt, locked} !== e) begin
        errors++;
        $display("FAIL reset_mid_after step %0d: got st=%0d idx=%0d fc=%0d lk=%0d, want st=%0d idx=%0d fc=%0d lk=%0d",
                 n, status, digit_idx, fail_cnt, locked, e.st, e.idx, e.fc, e.lk);
      end
      n++;
    end
  endtask

  task automatic test_fail_limit();
    exp_t e;
    int   n = 0;
    apply_reset();
    add_seq(24'h111111, 0, 0, 2, 1, 0);
    add(0, 0, 0, 0, 1, 0);
    add_seq(24'h111111, 0, 1, 2, 2, 0);
    add(0, 0, 0, 0, 2, 0);
`ifdef LOCKOUT_EN
    add_seq(24'h111111, 0, 2, 5, 3, 1);
`else
    add_seq(24'h111111, 0, 2, 2, 3, 0);
    add(0, 0, 0, 0, 3, 0);
    add_seq(24'h111111, 0, 3, 2, 3, 0);
    add(0, 0, 0, 0, 3, 0);
`endif
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      e = sb.pop_front();
      checks++;
      if ({status, digit_idx, fail_cnt, locked} !== e) begin
        errors++;
        $display("FAIL fail_limit step %0d: got st=%0d idx=%0d fc=%0d lk=%0d, want st=%0d idx=%0d fc=%0d lk=%0d",
                 n, status, digit_idx, fail_cnt, locked, e.st, e.idx, e.fc, e.lk);
      end
      n++;
    end
`ifdef LOCKOUT_EN
    // Hold enter high with an invalid digit: any accepted enter would show.
    enter = 1'b1;
    digit = 4'd10;
    for (int k = 1; k < LOCK; k++) begin
      @(negedge clk);
      checks++;
      if (status !== 3'd5 || locked !== 1'b1 || digit_idx !== 3'd0) begin
        errors++;
        $display("FAIL lockout cycle %0d: got st=%0d lk=%0d idx=%0d, want st=5 lk=1 idx=0",
                 k, status, locked, digit_idx);
      end
    end
    @(negedge clk);
    enter = 1'b0;
    checks++;
    if ({status, digit_idx, fail_cnt, locked} !== 9'b0) begin
      errors++;
      $display("FAIL lockout_exit: got st=%0d idx=%0d fc=%0d lk=%0d, want all 0",
               status, digit_idx, fail_cnt, locked);
    end
    add_seq(24'h285591, 0, 0, 1, 0, 0);
`else
    add_seq(24'h285591, 0, 3, 1, 0, 0);
`endif
    while (plan.size() > 0) begin
      drive(plan.pop_front());
      e = sb.pop_front();
      checks++;
      if ({status, digit_idx, fail_cnt, locked} !== e) begin
        errors++;
        $display("FAIL fail_limit_after step %0d: got st=%0d idx=%0d fc=%0d lk=%0d, want st=%0d idx=%0d fc=%0d lk=%0d",
                 n, status, digit_idx, fail_cnt, locked, e.st, e.idx, e.fc, e.lk);
      end
      n++;
    end
  endtask

  initial begin
    enter = 1'b0;
    digit = 4'd0;
    prog  = 1'b0;
    test_reset();
    test_open();
    test_error();
    test_closed();
    test_prog();
    test_reset_mid();
    test_fail_limit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
